// File: rtl/mmio_bridge.sv
// CPU-side MMIO bridge: RAM pass-through, UART TX FIFO, UART RX read port and cycle counter.
// Optional MMIO_CNT_SNAPSHOT_EN: a read of 0x30004 freezes the counter so 4-byte reads are coherent.
module mmio_bridge #(
  parameter int TX_FIFO_LOG = 3
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic [31:0] cpu_a,
  input  logic        cpu_wr,
  input  logic [7:0]  cpu_dout,
  output logic [7:0]  cpu_din,
  output logic        io_buffer_full,
  output logic [16:0] ram_a,
  output logic        ram_wr,
  output logic [7:0]  ram_din,
  input  logic [7:0]  ram_dout,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_pop,
  output logic        program_finish
);

  localparam logic [TX_FIFO_LOG:0] DEPTH   = (TX_FIFO_LOG+1)'(1) << TX_FIFO_LOG;
  localparam logic [TX_FIFO_LOG:0] FULL_TH = DEPTH - 1'b1;

  logic [17:0] w_a18;
  logic        w_io;
  logic        w_hit_tx;
  logic        w_hit_fin;
  logic        w_hit_cnt;
  logic        w_push_req;
  logic        w_push;
  logic        w_pop;
  logic [7:0]  w_push_byte;
  logic [7:0]  w_io_byte;
  logic [7:0]  w_cnt_byte;
  logic [31:0] w_cnt_src;
  logic        w_unused;

  logic [TX_FIFO_LOG-1:0] r_wr_ptr;
  logic [TX_FIFO_LOG-1:0] r_rd_ptr;
  logic [TX_FIFO_LOG:0]   r_count;
  logic [7:0]             r_fifo [0:(1<<TX_FIFO_LOG)-1];
  logic [31:0]            r_cnt;
  logic                   r_sel_ram;
  logic [7:0]             r_io_byte;
  logic                   r_finish;

  assign w_unused  = ^cpu_a[31:18];
  assign w_a18     = cpu_a[17:0];
  assign w_io      = (cpu_a[17:16] == 2'b11);
  assign w_hit_tx  = (w_a18 == 18'h30000);
  assign w_hit_fin = (w_a18 == 18'h30004);
  assign w_hit_cnt = (w_a18[17:2] == 16'hC001);

  assign ram_a   = cpu_a[16:0];
  assign ram_din = cpu_dout;
  assign ram_wr  = cpu_wr & ~w_io & rdy_in;

  // ---------------- TX FIFO ----------------
  assign tx_valid       = (r_count != '0);
  assign tx_data        = r_fifo[r_rd_ptr];
  assign io_buffer_full = (r_count >= FULL_TH);
  assign w_pop          = tx_valid & tx_ready;
  assign w_push_req     = rdy_in & cpu_wr & ((w_hit_tx & (cpu_dout != 8'h00)) | w_hit_fin);
  assign w_push_byte    = w_hit_fin ? 8'h00 : cpu_dout;
  // A full FIFO still accepts when the head leaves in the same cycle.
  assign w_push         = w_push_req & ((r_count < DEPTH) | w_pop);

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (w_push) r_fifo[r_wr_ptr] <= w_push_byte;
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in)                                 r_finish <= 1'b0;
    else if (rdy_in & cpu_wr & w_hit_fin)        r_finish <= 1'b1;
  end
  assign program_finish = r_finish;

  // ---------------- counter and read path ----------------
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in)     r_cnt <= '0;
    else if (rdy_in) r_cnt <= r_cnt + 32'd1;
  end

`ifdef MMIO_CNT_SNAPSHOT_EN
  logic [31:0] r_snap;
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in)                             r_snap <= '0;
    else if (rdy_in & ~cpu_wr & w_hit_fin)   r_snap <= r_cnt;
  end
  // Byte 0 comes straight from the counter while the snapshot is being taken.
  assign w_cnt_src = (w_a18[1:0] == 2'd0) ? r_cnt : r_snap;
`else
  assign w_cnt_src = r_cnt;
`endif

  always_comb begin
    w_cnt_byte = 8'h00;
    case (w_a18[1:0])
      2'd0:    w_cnt_byte = w_cnt_src[7:0];
      2'd1:    w_cnt_byte = w_cnt_src[15:8];
      2'd2:    w_cnt_byte = w_cnt_src[23:16];
      default: w_cnt_byte = w_cnt_src[31:24];
    endcase
  end

  always_comb begin
    w_io_byte = 8'h00;
    if (w_hit_tx)       w_io_byte = rx_valid ? rx_data : 8'h00;
    else if (w_hit_cnt) w_io_byte = w_cnt_byte;
  end

  assign rx_pop = rst_in & rdy_in & ~cpu_wr & w_hit_tx & rx_valid;

  // IO bytes are captured at request time because the RX head moves on pop.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_sel_ram <= 1'b1;
      r_io_byte <= 8'h00;
    end else if (rdy_in) begin
      r_sel_ram <= ~w_io;
      r_io_byte <= w_io_byte;
    end
  end

  assign cpu_din = r_sel_ram ? ram_dout : r_io_byte;

endmodule

// File: tb/tb_mmio_bridge.sv
// Self-checking bench for mmio_bridge: directed steps plus random traffic against a queue-based model.
module tb_mmio_bridge;
  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic        rdy_in = 1'b0;
  logic [31:0] cpu_a = '0;
  logic        cpu_wr = 1'b0;
  logic [7:0]  cpu_dout = '0;
  logic [7:0]  cpu_din;
  logic        io_buffer_full;
  logic [16:0] ram_a;
  logic        ram_wr;
  logic [7:0]  ram_din;
  logic [7:0]  ram_dout;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic        rx_pop;
  logic        program_finish;

  mmio_bridge #(.TX_FIFO_LOG(3)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .cpu_a(cpu_a), .cpu_wr(cpu_wr), .cpu_dout(cpu_dout), .cpu_din(cpu_din),
    .io_buffer_full(io_buffer_full),
    .ram_a(ram_a), .ram_wr(ram_wr), .ram_din(ram_din), .ram_dout(ram_dout),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_pop(rx_pop),
    .program_finish(program_finish)
  );

  always #5 clk_in = ~clk_in;

  // Small RAM with one-cycle read latency; only the low 9 address bits are modelled.
  logic [7:0] mem [0:511];
  logic       unused_bits;
  assign unused_bits = ^ram_a[16:9];
  always @(posedge clk_in) begin
    if (ram_wr) mem[ram_a[8:0]] <= ram_din;
    ram_dout <= mem[ram_a[8:0]];
  end

  int          n_vec = 0;
  int          n_err = 0;
  logic [7:0]  m_q[$];
  bit          m_fin = 1'b0;
  logic [31:0] m_cnt = '0;
  logic [31:0] m_snap = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [31:0] a, input logic wr, input logic [7:0] d);
    cpu_a = a; cpu_wr = wr; cpu_dout = d;
  endtask

  // One clock: check combinational outputs, step the model, then check registered outputs.
  task automatic cycle();
    logic [17:0] a;
    logic        io;
    logic        rd_now;
    logic [7:0]  rb;
    #1;
    a  = cpu_a[17:0];
    io = (a[17:16] == 2'b11);
    rd_now = rdy_in && !cpu_wr;
    rb = 8'h00;
    chk("ram_a", 32'(ram_a), 32'(cpu_a[16:0]));
    chk("ram_din", 32'(ram_din), 32'(cpu_dout));
    chk("ram_wr", 32'(ram_wr), 32'(cpu_wr && !io && rdy_in));
    chk("rx_pop", 32'(rx_pop), 32'(io && !cpu_wr && a == 18'h30000 && rx_valid && rdy_in));
    if (rd_now) begin
      if (!io)                                rb = mem[a[8:0]];
      else if (a == 18'h30000)                rb = rx_valid ? rx_data : 8'h00;
      else if (a >= 18'h30004 && a <= 18'h30007) begin
`ifdef MMIO_CNT_SNAPSHOT_EN
        if (a == 18'h30004) m_snap = m_cnt;
        rb = 8'(m_snap >> (8 * (a - 18'h30004)));
`else
        rb = 8'(m_cnt >> (8 * (a - 18'h30004)));
`endif
      end
    end
    if (m_q.size() != 0 && tx_ready) void'(m_q.pop_front());
    if (rdy_in && cpu_wr && io) begin
      if (a == 18'h30004) begin
        m_fin = 1'b1;
        if (m_q.size() < 8) m_q.push_back(8'h00);
      end else if (a == 18'h30000 && cpu_dout != 8'h00 && m_q.size() < 8) begin
        m_q.push_back(cpu_dout);
      end
    end
    if (rdy_in) m_cnt++;
    @(posedge clk_in); #1;
    if (rd_now) chk("cpu_din", 32'(cpu_din), 32'(rb));
    chk("tx_valid", 32'(tx_valid), 32'(m_q.size() != 0));
    if (m_q.size() != 0) chk("tx_data", 32'(tx_data), 32'(m_q[0]));
    chk("io_buffer_full", 32'(io_buffer_full), 32'(m_q.size() >= 7));
    chk("program_finish", 32'(program_finish), 32'(m_fin));
  endtask

  function automatic logic [31:0] ram_addr(input int i);
    return (i < 16) ? 32'(i) : 32'(32'h100 + i - 16);
  endfunction

  initial begin
    // Reset state
    rdy_in = 1'b1; rx_valid = 1'b1; rx_data = 8'hA5;
    drive(32'h30000, 1'b0, 8'h00);
    repeat (3) @(posedge clk_in);
    #1;
    chk("rst_tx_valid", 32'(tx_valid), 32'd0);
    chk("rst_full", 32'(io_buffer_full), 32'd0);
    chk("rst_finish", 32'(program_finish), 32'd0);
    chk("rst_rx_pop", 32'(rx_pop), 32'd0);
    rx_valid = 1'b0;
    drive(32'h0, 1'b0, 8'h00);
    rst_in = 1'b1;

    // Preload RAM through the bridge
    for (int i = 0; i < 32; i++) begin
      drive(ram_addr(i), 1'b1, 8'($urandom));
      cycle();
    end

    // Two bytes out with the UART ready
    tx_ready = 1'b1;
    drive(32'h30000, 1'b1, 8'h41); cycle();
    drive(32'h30000, 1'b1, 8'h42); cycle();
    drive(32'h0, 1'b0, 8'h00);
    repeat (3) cycle();

    // Fill with UART stalled, 9th byte dropped, then drain
    tx_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      drive(32'h30000, 1'b1, 8'(8'h10 + i)); cycle();
    end
    drive(32'h0, 1'b0, 8'h00);
    tx_ready = 1'b1;
    repeat (10) cycle();

    // Zero byte ignored; finish write emits 0x00 and latches the halt flag
    drive(32'h30000, 1'b1, 8'h00); cycle();
    drive(32'h30004, 1'b1, 8'h77); cycle();
    drive(32'h0, 1'b0, 8'h00);
    repeat (3) cycle();

    // RX read with and without a byte waiting
    rx_valid = 1'b1; rx_data = 8'h5A;
    drive(32'h30000, 1'b0, 8'h00); cycle();
    rx_valid = 1'b0;
    cycle();

    // Counter bytes read back-to-back starting at 0x000001FF
    drive(32'h0, 1'b0, 8'h00);
    for (int i = 0; i < 2000 && m_cnt != 32'h1FF; i++) cycle();
    chk("cnt_reached", m_cnt, 32'h1FF);
    for (int k = 0; k < 4; k++) begin
      drive(32'h30004 + 32'(k), 1'b0, 8'h00); cycle();
    end

    // Frozen bus: no push, no pop pulse
    rdy_in = 1'b0; rx_valid = 1'b1; tx_ready = 1'b0;
    drive(32'h30000, 1'b1, 8'h99); cycle();
    drive(32'h30000, 1'b0, 8'h00); cycle();
    rdy_in = 1'b1; rx_valid = 1'b0;

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      logic [17:0] a;
      case ($urandom_range(0, 7))
        0, 1, 2: a = 18'(ram_addr($urandom_range(0, 31)));
        3, 4:    a = 18'h30000;
        5:       a = 18'h30004 + 18'($urandom_range(0, 3));
        6:       a = 18'h30008 + 18'($urandom_range(0, 255));
        default: a = 18'h3FFFF;
      endcase
      drive({14'($urandom), a}, ($urandom_range(0, 2) == 0),
            ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom));
      rdy_in   = ($urandom_range(0, 7) != 0);
      tx_ready = $urandom_range(0, 1) == 1;
      rx_valid = $urandom_range(0, 1) == 1;
      rx_data  = 8'($urandom);
      cycle();
    end

    // Reset in the middle of a queued transfer
    rdy_in = 1'b1; tx_ready = 1'b0; rx_valid = 1'b0;
    drive(32'h30004, 1'b1, 8'h00); cycle();
    for (int i = 0; i < 3; i++) begin
      drive(32'h30000, 1'b1, 8'(8'hC0 + i)); cycle();
    end
    rx_valid = 1'b1;
    drive(32'h30000, 1'b0, 8'h00);
    rst_in = 1'b0;
    #1;
    chk("midrst_tx_valid", 32'(tx_valid), 32'd0);
    chk("midrst_finish", 32'(program_finish), 32'd0);
    chk("midrst_full", 32'(io_buffer_full), 32'd0);
    chk("midrst_rx_pop", 32'(rx_pop), 32'd0);
    repeat (2) @(posedge clk_in);
    #1;
    m_q.delete(); m_fin = 1'b0; m_cnt = '0; m_snap = '0;
    rx_valid = 1'b0; tx_ready = 1'b1;
    drive(32'h0, 1'b0, 8'h00);
    rst_in = 1'b1;
    drive(32'h00100, 1'b0, 8'h00); cycle();
    drive(32'h0, 1'b0, 8'h00); cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/mmio_bridge.md
MMIO_BRIDGE -- requirements
Module: mmio_bridge

Interface
REQ-001 SHALL have parameter TX_FIFO_LOG, default 3, log2 of TX FIFO depth (depth D = 8).
REQ-002 SHALL have ports as listed in REQ-003 to REQ-018; reset is asynchronous and active-low; one clock.
REQ-003 clk_in  input  1  system clock, all state on rising edge.
REQ-004 rst_in  input  1  asynchronous active-low reset.
REQ-005 rdy_in  input  1  global ready; low freezes CPU-side state.
REQ-006 cpu_a  input  32  CPU address bus (17:0 used).
REQ-007 cpu_wr  input  1  1 = write.
REQ-008 cpu_dout  input  8  CPU write data.
REQ-009 cpu_din  output  8  read data to CPU, valid the cycle after the request.
REQ-010 io_buffer_full  output  1  UART TX backpressure to CPU.
REQ-011 ram_a  output  17  RAM address.
REQ-012 ram_wr  output  1  RAM write enable.
REQ-013 ram_din  output  8  RAM write data.
REQ-014 ram_dout  input  8  RAM read data (1-cycle latency).
REQ-015 tx_data  output  8 and tx_valid  output  1  UART TX byte and valid.
REQ-016 tx_ready  input  1  UART accepts byte when tx_valid and tx_ready are both high.
REQ-017 rx_data  input  8, rx_valid  input  1 and rx_pop  output  1  UART RX head byte, its valid flag, and a 1-cycle dequeue pulse.
REQ-018 program_finish  output  1  sticky halt flag.

Function
REQ-019 Decode: io = (cpu_a[17:16] == 2'b11); otherwise RAM.
REQ-020 RAM path is combinational: ram_a = cpu_a[16:0]; ram_din = cpu_dout; ram_wr = cpu_wr & ~io & rdy_in.
REQ-021 Read select (RAM / RX / CNT byte 0-3) SHALL be registered when rdy_in is high; cpu_din is muxed from that registered select (1-cycle latency).
REQ-022 IO write 0x30000 with a nonzero byte SHALL push to the TX FIFO; a 0x00 byte is ignored.
REQ-023 IO write 0x30004 SHALL push 0x00 to the TX FIFO and set program_finish; program_finish stays set until reset.
REQ-024 FIFO push is accepted if count < D, or if count == D and a pop happens in the same cycle. Otherwise the byte is dropped and count is unchanged.
REQ-025 tx_valid = (count != 0); tx_data = head entry; pop on tx_valid & tx_ready; the pop is independent of rdy_in.
REQ-026 Pointers are TX_FIFO_LOG bits and wrap modulo D; count is TX_FIFO_LOG+1 bits.
REQ-027 io_buffer_full = (count >= D-1), combinational from registered count.
REQ-028 IO read 0x30000 SHALL return rx_data if rx_valid, else 0x00. rx_pop pulses for one cycle only if rx_valid and rdy_in.
REQ-029 A 32-bit cycle counter increments each cycle rdy_in is high and wraps at 2^32.
REQ-030 IO read 0x30004..0x30007 SHALL return counter byte (addr - 0x30004), little-endian.
REQ-031 With rdy_in low: no push, no rx_pop, counter holds, registered select holds.
REQ-032 IO accesses to other addresses: writes ignored, reads return 0x00.

Reset
REQ-033 While rst_in is low: count, pointers, counter, select (RAM), and program_finish SHALL clear. rx_pop = 0, tx_valid = 0, io_buffer_full = 0.
REQ-034 Reset asserted mid-transfer SHALL discard all queued TX bytes.

Configuration
REQ-035 Macro MMIO_CNT_SNAPSHOT_EN: when defined, a read of 0x30004 latches the full counter into a 32-bit snapshot register, and reads of 0x30004-0x30007 return snapshot bytes, so a 4-byte read is coherent. When undefined, the counter is sampled live per byte and there is no snapshot register.

Verification
REQ-036 Write 0x41 then 0x42 to 0x30000 with tx_ready = 1 -> tx_data 0x41 then 0x42, each for one handshake, FIFO empty after.
REQ-037 tx_ready = 0, 8 nonzero writes -> io_buffer_full high after the 7th write; the 9th write is dropped; draining yields exactly 8 bytes in order.
REQ-038 Write 0x00 to 0x30000 -> no push. Write to 0x30004 -> 0x00 emitted on TX, program_finish = 1 persists.
REQ-039 rx_valid = 1, rx_data = 0x5A, read 0x30000 -> cpu_din = 0x5A next cycle, rx_pop single pulse. With rx_valid = 0 -> 0x00 and no pulse.
REQ-040 Counter at 0x000001FF, read 0x30004..0x30007 on consecutive cycles -> with macro: FF,01,00,00; without: FF,02,00,00 (live, incremented).
REQ-041 rst_in low during a queued transfer -> tx_valid = 0 and program_finish = 0 immediately. Reads of 0x00100 return ram_dout one cycle later.
